vga_fb_arbiter: RTL and testbench

//  Owns the single-port framebuffer RAM shared by VGA scan-out and a host writer. Runs the raster

---
 rtl/vga_fb_arbiter_pkg.sv | 35 +++
 rtl/vga_fb_arbiter_if.sv | 45 ++++
 rtl/vga_fb_arbiter_timing.sv | 91 +++++++++
 rtl/vga_fb_arbiter.sv | 113 +++++++++++
 tb/tb_vga_fb_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_fb_arbiter_pkg.sv
// Shared definitions for the VGA framebuffer arbiter.
// Contents:
//   - default 640x480@60 timing constants
//   - h_total/v_total helpers and a counter-width helper
//   - region_e: the vertical region FSM state (active lines vs. vertical blanking)
package vga_fb_arbiter_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic {
        V_ACT   = 1'b0,
        V_BLANK = 1'b1
    } region_e;

    function automatic int h_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    // Bits needed to hold 0..total-1.
    function automatic int cnt_w(int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Bundle of the arbiter's host write port, RAM port and video output.
// Handshake: a host write transfers on a rising edge where host_valid and
// host_ready are both 1. host_ready does not depend on host_valid; once the host
// raises host_valid it keeps host_valid/host_addr/host_data stable until the
// transfer happens. The RAM port has no handshake: mem_en is a one-cycle strobe
// and read data returns on mem_rdata one clock after a read strobe.
// Modports:
//   master - the arbiter (drives host_ready/host_err, the RAM strobe and video)
//   slave  - the environment (host, RAM, DAC)
interface vga_fb_arbiter_if #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 19
);
    logic              host_valid;
    logic [ADDR_W-1:0] host_addr;
    logic [PIX_W-1:0]  host_data;
    logic              host_ready;
    logic              host_err;
    logic              err_clr;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_wdata;
    logic [PIX_W-1:0]  mem_rdata;

    logic [PIX_W-1:0]  pix_out;
    logic              pix_de;
    logic              h_sync;
    logic              v_sync;
    logic              frame_start;

    modport master (
        input  host_valid, host_addr, host_data, err_clr, mem_rdata,
        output host_ready, host_err, mem_en, mem_we, mem_addr, mem_wdata,
        output pix_out, pix_de, h_sync, v_sync, frame_start
    );

    modport slave (
        output host_valid, host_addr, host_data, err_clr, mem_rdata,
        input  host_ready, host_err, mem_en, mem_we, mem_addr, mem_wdata,
        input  pix_out, pix_de, h_sync, v_sync, frame_start
    );

endinterface

// File: rtl/vga_fb_arbiter_timing.sv
// Raster timing generator: h/v counters, vertical region FSM and the raw
// (undelayed) decode of the current counter position.
// Ports:
//   pixel_clk, reset  clock and synchronous active-high reset
//   fetch_o           current cycle is an active-video pixel (RAM fetch slot)
//   h_sync_o/v_sync_o raw sync levels for the current position
//   frame_start_o     current position is h=0, v=0
//   region_o          region FSM state (also used for debug)
module vga_fb_arbiter_timing
    import vga_fb_arbiter_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic    pixel_clk,
    input  logic    reset,
    output logic    fetch_o,
    output logic    h_sync_o,
    output logic    v_sync_o,
    output logic    frame_start_o,
    output region_e region_o
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = cnt_w(H_TOTAL);
    localparam int VW      = cnt_w(V_TOTAL);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    region_e       region_q, region_d;
    logic          h_wrap;

    assign h_wrap = (h_cnt_q == HW'(H_TOTAL - 1));

    always_comb begin
        h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + VW'(1);
        end
    end

    // Region only changes at the end of a line, so it always describes the
    // line currently being scanned.
    always_comb begin
        region_d = region_q;
        case (region_q)
            V_ACT: begin
                if (h_wrap && v_cnt_q == VW'(V_ACTIVE - 1)) region_d = V_BLANK;
            end
            V_BLANK: begin
                if (h_wrap && v_cnt_q == VW'(V_TOTAL - 1)) region_d = V_ACT;
            end
            default: region_d = V_ACT;
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            region_q <= V_ACT;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            region_q <= region_d;
        end
    end

    logic in_hs, in_vs;
    assign in_hs = (h_cnt_q >= HW'(H_ACTIVE + H_FP)) &&
                   (h_cnt_q <= HW'(H_ACTIVE + H_FP + H_SYNC - 1));
    assign in_vs = (v_cnt_q >= VW'(V_ACTIVE + V_FP)) &&
                   (v_cnt_q <= VW'(V_ACTIVE + V_FP + V_SYNC - 1));

    assign fetch_o       = (region_q == V_ACT) && (h_cnt_q < HW'(H_ACTIVE));
    assign h_sync_o      = in_hs ? HS_POL : ~HS_POL;
    assign v_sync_o      = in_vs ? VS_POL : ~VS_POL;
    assign frame_start_o = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign region_o      = region_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter for VGA scan-out plus host writes.
// Every active-video cycle issues a pixel read; every other cycle is a free slot
// in which a host write is granted. Video outputs are delayed one clock so they
// line up with the RAM read data.
// Ports:
//   pixel_clk, reset  sole clock, synchronous active-high reset
//   bus               host write port, RAM port and video outputs (master side)
//   dbg_region_o      region FSM state
module vga_fb_arbiter
    import vga_fb_arbiter_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIX_W    = 8,
    parameter int ADDR_W   = 19
) (
    input  logic               pixel_clk,
    input  logic               reset,
    vga_fb_arbiter_if.master   bus,
    output region_e            dbg_region_o
);

    localparam int NPIX = H_ACTIVE * V_ACTIVE;

    logic fetch, hs_raw, vs_raw, fs_raw;

    vga_fb_arbiter_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) u_timing (
        .pixel_clk     (pixel_clk),
        .reset         (reset),
        .fetch_o       (fetch),
        .h_sync_o      (hs_raw),
        .v_sync_o      (vs_raw),
        .frame_start_o (fs_raw),
        .region_o      (dbg_region_o)
    );

    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d, fetch_addr;
    logic              host_err_q, host_err_d;
    logic              de_q, hs_q, vs_q, fs_q;
    logic              free_slot, accept, in_range;

    // Extra top bit so NPIX == 2^ADDR_W still compares correctly.
    assign in_range  = {1'b0, bus.host_addr} < (ADDR_W + 1)'(NPIX);
    assign free_slot = !reset && !fetch;
    assign accept    = bus.host_valid && free_slot;

    // Frame origin restarts the linear scan address without a multiplier.
    assign fetch_addr = fs_raw ? '0 : fb_addr_q;

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        fb_addr_d     = fb_addr_q;
        if (!reset && fetch) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = fetch_addr;
            fb_addr_d    = fetch_addr + ADDR_W'(1);
        end else if (accept && in_range) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = bus.host_addr;
            bus.mem_wdata = bus.host_data;
        end
    end

    // A new error takes priority over a simultaneous clear.
    always_comb begin
        host_err_d = host_err_q;
        if (accept && !in_range) host_err_d = 1'b1;
        else if (bus.err_clr)    host_err_d = 1'b0;
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            fb_addr_q  <= '0;
            host_err_q <= 1'b0;
            de_q       <= 1'b0;
            hs_q       <= ~HS_POL;
            vs_q       <= ~VS_POL;
            fs_q       <= 1'b0;
        end else begin
            fb_addr_q  <= fb_addr_d;
            host_err_q <= host_err_d;
            de_q       <= fetch;
            hs_q       <= hs_raw;
            vs_q       <= vs_raw;
            fs_q       <= fs_raw;
        end
    end

    assign bus.host_ready  = free_slot;
    assign bus.host_err    = host_err_q;
    assign bus.pix_de      = de_q;
    assign bus.h_sync      = hs_q;
    assign bus.v_sync      = vs_q;
    assign bus.frame_start = fs_q;
    assign bus.pix_out     = de_q ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter using a reduced raster (48x16 total, 32x8 active)
// so a whole frame is 768 clocks.
module tb_vga_fb_arbiter;
    import vga_fb_arbiter_pkg::*;

    localparam int HA = 32, HFP = 4, HS = 8, HBP = 4;
    localparam int VA = 8,  VFP = 2, VS = 2, VBP = 4;
    localparam int HT = 48, VT = 16, FRAME = 768;

    logic    pixel_clk = 1'b0;
    logic    reset;
    logic    init_ram;
    region_e dbg_region;
    int      pos;
    int      tests_run = 0;
    int      fails = 0;
    logic [7:0] ram [512];

    vga_fb_arbiter_if #(.PIX_W(8), .ADDR_W(9)) bus ();

    vga_fb_arbiter #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIX_W(8), .ADDR_W(9)
    ) dut (
        .pixel_clk    (pixel_clk),
        .reset        (reset),
        .bus          (bus),
        .dbg_region_o (dbg_region)
    );

    // clock / reset-position reference
    always #5 pixel_clk = ~pixel_clk;

    always @(posedge pixel_clk) begin
        if (reset) pos <= 0;
        else       pos <= pos + 1;
    end

    // RAM model: contents start as addr[7:0], read data one clock after strobe
    always @(posedge pixel_clk) begin
        if (init_ram) begin
            for (int i = 0; i < 512; i++) ram[i] <= i[7:0];
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks (all start and end just after a falling edge)
    task automatic do_reset();
        @(negedge pixel_clk);
        reset = 1'b1;
        bus.host_valid = 1'b0;
        bus.err_clr = 1'b0;
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic wait_pos(input int target);
        int n;
        n = 0;
        while (pos != target && n < 4000) begin
            @(negedge pixel_clk);
            n++;
        end
        #1;
        tests_run++;
        if (pos != target) begin
            fails++;
            $display("FAIL wait_pos: reached %0d, required %0d", pos, target);
        end
    endtask

    task automatic test_reset();
        init_ram = 1'b1;
        @(negedge pixel_clk);
        reset = 1'b1;
        bus.host_valid = 1'b1;
        bus.host_addr = 9'd5;
        bus.host_data = 8'h33;
        @(negedge pixel_clk);
        init_ram = 1'b0;
        #1;
        tests_run++; if (bus.host_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", bus.host_ready); end
        tests_run++; if (bus.mem_en !== 1'b0) begin fails++; $display("FAIL rst_mem_en: got %b want 0", bus.mem_en); end
        tests_run++; if (bus.pix_de !== 1'b0) begin fails++; $display("FAIL rst_de: got %b want 0", bus.pix_de); end
        tests_run++; if (bus.pix_out !== 8'h00) begin fails++; $display("FAIL rst_pix: got %h want 00", bus.pix_out); end
        tests_run++; if (bus.h_sync !== 1'b1) begin fails++; $display("FAIL rst_hs: got %b want 1", bus.h_sync); end
        tests_run++; if (bus.v_sync !== 1'b1) begin fails++; $display("FAIL rst_vs: got %b want 1", bus.v_sync); end
        tests_run++; if (bus.frame_start !== 1'b0) begin fails++; $display("FAIL rst_fs: got %b want 0", bus.frame_start); end
        tests_run++; if (bus.host_err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", bus.host_err); end
        tests_run++; if (dbg_region !== V_ACT) begin fails++; $display("FAIL rst_region: got %0d want 0", dbg_region); end
        @(negedge pixel_clk);
        reset = 1'b0;
        bus.host_valid = 1'b0;
        #1;
        tests_run++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 9'd0) begin
            fails++; $display("FAIL first_fetch: en=%b we=%b addr=%0d want 1 0 0", bus.mem_en, bus.mem_we, bus.mem_addr);
        end
        tests_run++; if (bus.frame_start !== 1'b0) begin fails++; $display("FAIL fs_early: got %b want 0", bus.frame_start); end
        @(negedge pixel_clk); #1;
        tests_run++; if (bus.frame_start !== 1'b1 || bus.pix_de !== 1'b1) begin
            fails++; $display("FAIL fs_first: fs=%b de=%b want 1 1", bus.frame_start, bus.pix_de);
        end
        tests_run++; if (bus.mem_addr !== 9'd1) begin fails++; $display("FAIL second_fetch: addr=%0d want 1", bus.mem_addr); end
        @(negedge pixel_clk); #1;
        tests_run++; if (bus.frame_start !== 1'b0) begin fails++; $display("FAIL fs_pulse: got %b want 0", bus.frame_start); end
    endtask

    task automatic test_frame();
        int fs_n, de_n, hs_n, vs_n, fetch_n, model_err, zero_err, prev, h, v, cv;
        logic e_de, e_hs, e_vs;
        region_e e_reg;
        fs_n = 0; de_n = 0; hs_n = 0; vs_n = 0; fetch_n = 0; model_err = 0; zero_err = 0;
        do_reset();
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge pixel_clk); #1;
            prev = pos - 1;
            h = prev % HT;
            v = prev / HT;
            e_de = (h < HA) && (v < VA);
            e_hs = !(h >= 36 && h <= 43);
            e_vs = !(v >= 10 && v <= 11);
            cv = (pos % FRAME) / HT;
            e_reg = (cv < VA) ? V_ACT : V_BLANK;
            if (bus.frame_start === 1'b1) fs_n++;
            if (bus.pix_de === 1'b1) de_n++;
            if (bus.h_sync === 1'b0) hs_n++;
            if (bus.v_sync === 1'b0) vs_n++;
            if (bus.mem_en === 1'b1 && bus.mem_we === 1'b0) fetch_n++;
            if (bus.pix_de !== e_de || bus.h_sync !== e_hs || bus.v_sync !== e_vs || dbg_region !== e_reg) model_err++;
            if (bus.pix_de === 1'b0 && bus.pix_out !== 8'h00) zero_err++;
        end
        tests_run++; if (fs_n != 1) begin fails++; $display("FAIL frame_fs_count: got %0d want 1", fs_n); end
        tests_run++; if (de_n != 256) begin fails++; $display("FAIL frame_de_count: got %0d want 256", de_n); end
        tests_run++; if (hs_n != 128) begin fails++; $display("FAIL frame_hs_low: got %0d want 128", hs_n); end
        tests_run++; if (vs_n != 96) begin fails++; $display("FAIL frame_vs_low: got %0d want 96", vs_n); end
        tests_run++; if (fetch_n != 256) begin fails++; $display("FAIL frame_fetches: got %0d want 256", fetch_n); end
        tests_run++; if (model_err != 0) begin fails++; $display("FAIL frame_timing: %0d cycles differ, want 0", model_err); end
        tests_run++; if (zero_err != 0) begin fails++; $display("FAIL frame_blank_pix: %0d nonzero, want 0", zero_err); end
    endtask

    task automatic test_pixel();
        do_reset();
        wait_pos(50);   // x=1,y=1 -> addr 33
        tests_run++; if (bus.pix_de !== 1'b1 || bus.pix_out !== 8'h21) begin
            fails++; $display("FAIL pix_x1y1: de=%b pix=%h want 1 21", bus.pix_de, bus.pix_out);
        end
        wait_pos(81);   // h=32 on line 1: blanking
        tests_run++; if (bus.pix_de !== 1'b0 || bus.pix_out !== 8'h00) begin
            fails++; $display("FAIL pix_blank: de=%b pix=%h want 0 00", bus.pix_de, bus.pix_out);
        end
        wait_pos(102);  // x=5,y=2 -> addr 69
        tests_run++; if (bus.pix_de !== 1'b1 || bus.pix_out !== 8'h45) begin
            fails++; $display("FAIL pix_x5y2: de=%b pix=%h want 1 45", bus.pix_de, bus.pix_out);
        end
    endtask

    task automatic test_host_wait();
        int waited, lost, acc_pos;
        bit got;
        waited = 0; lost = 0; acc_pos = -1; got = 0;
        do_reset();
        wait_pos(10);
        bus.host_valid = 1'b1;
        bus.host_addr = 9'd64;
        bus.host_data = 8'hA5;
        while (!got && waited < 100) begin
            #1;
            if (bus.host_ready === 1'b1) begin
                got = 1;
                acc_pos = pos;
                tests_run++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 9'd64 || bus.mem_wdata !== 8'hA5) begin
                    fails++; $display("FAIL host_strobe: en=%b we=%b addr=%0d data=%h want 1 1 64 a5",
                                      bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
                end
            end else begin
                if (!(bus.mem_en === 1'b1 && bus.mem_we === 1'b0 && bus.mem_addr === 9'(pos))) lost++;
                @(negedge pixel_clk);
                waited++;
            end
        end
        tests_run++; if (acc_pos != 32) begin fails++; $display("FAIL host_ready_pos: got %0d want 32", acc_pos); end
        tests_run++; if (lost != 0) begin fails++; $display("FAIL host_fetch_lost: got %0d want 0", lost); end
        @(negedge pixel_clk);
        bus.host_valid = 1'b0;
        #1;
        tests_run++; if (ram[64] !== 8'hA5) begin fails++; $display("FAIL host_ram: got %h want a5", ram[64]); end
        wait_pos(97);   // x=0,y=2 shows the written pixel
        tests_run++; if (bus.pix_out !== 8'hA5) begin fails++; $display("FAIL host_pix: got %h want a5", bus.pix_out); end
        @(negedge pixel_clk); #1;
        tests_run++; if (bus.pix_out !== 8'h41) begin fails++; $display("FAIL host_pix_next: got %h want 41", bus.pix_out); end
    endtask

    task automatic test_back_to_back();
        int accepts, drops, bad;
        accepts = 0; drops = 0; bad = 0;
        do_reset();
        wait_pos(384);
        tests_run++; if (dbg_region !== V_BLANK) begin fails++; $display("FAIL b2b_region: got %0d want 1", dbg_region); end
        for (int i = 0; i < 300; i++) begin
            bus.host_valid = 1'b1;
            bus.host_addr = 9'(128 + (i % 128));
            bus.host_data = 8'(i) ^ 8'h5A;
            #1;
            if (bus.host_ready === 1'b1) begin
                accepts++;
                if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== bus.host_addr || bus.mem_wdata !== bus.host_data) bad++;
            end else begin
                drops++;
            end
            @(negedge pixel_clk);
        end
        bus.host_valid = 1'b0;
        #1;
        tests_run++; if (accepts != 300) begin fails++; $display("FAIL b2b_accepts: got %0d want 300", accepts); end
        tests_run++; if (drops != 0) begin fails++; $display("FAIL b2b_ready_drop: got %0d want 0", drops); end
        tests_run++; if (bad != 0) begin fails++; $display("FAIL b2b_strobe: got %0d bad want 0", bad); end
        tests_run++; if (ram[171] !== 8'h71) begin fails++; $display("FAIL b2b_ram171: got %h want 71", ram[171]); end
        tests_run++; if (ram[128] !== 8'h5A) begin fails++; $display("FAIL b2b_ram128: got %h want 5a", ram[128]); end
    endtask

    task automatic test_error();
        do_reset();
        wait_pos(400);
        bus.host_valid = 1'b1;
        bus.host_addr = 9'd256;
        bus.host_data = 8'hFF;
        #1;
        tests_run++; if (bus.host_ready !== 1'b1 || bus.mem_en !== 1'b0) begin
            fails++; $display("FAIL err_accept: ready=%b en=%b want 1 0", bus.host_ready, bus.mem_en);
        end
        @(negedge pixel_clk);
        bus.host_valid = 1'b0;
        #1;
        tests_run++; if (bus.host_err !== 1'b1) begin fails++; $display("FAIL err_set: got %b want 1", bus.host_err); end
        tests_run++; if (ram[256] !== 8'h00) begin fails++; $display("FAIL err_nowrite: got %h want 00", ram[256]); end
        bus.err_clr = 1'b1;
        @(negedge pixel_clk);
        bus.err_clr = 1'b0;
        #1;
        tests_run++; if (bus.host_err !== 1'b0) begin fails++; $display("FAIL err_clear: got %b want 0", bus.host_err); end
        bus.host_valid = 1'b1;
        bus.host_addr = 9'd300;
        bus.err_clr = 1'b1;
        @(negedge pixel_clk);
        bus.host_valid = 1'b0;
        bus.err_clr = 1'b0;
        #1;
        tests_run++; if (bus.host_err !== 1'b1) begin fails++; $display("FAIL err_set_wins: got %b want 1", bus.host_err); end
        tests_run++; if (ram[300] !== 8'h2C) begin fails++; $display("FAIL err_nowrite300: got %h want 2c", ram[300]); end
    endtask

    task automatic test_mid_reset();
        // h=20 on line 5 of the second frame (host_err still set from before)
        wait_pos(FRAME + 5 * HT + 20);
        tests_run++; if (bus.host_err !== 1'b1) begin fails++; $display("FAIL mid_err_before: got %b want 1", bus.host_err); end
        reset = 1'b1;
        @(negedge pixel_clk); #1;
        tests_run++; if (bus.mem_en !== 1'b0 || bus.host_ready !== 1'b0 || bus.host_err !== 1'b0) begin
            fails++; $display("FAIL mid_ctrl: en=%b ready=%b err=%b want 0 0 0", bus.mem_en, bus.host_ready, bus.host_err);
        end
        tests_run++; if (bus.pix_de !== 1'b0 || bus.pix_out !== 8'h00 || bus.frame_start !== 1'b0) begin
            fails++; $display("FAIL mid_video: de=%b pix=%h fs=%b want 0 00 0", bus.pix_de, bus.pix_out, bus.frame_start);
        end
        tests_run++; if (bus.h_sync !== 1'b1 || bus.v_sync !== 1'b1) begin
            fails++; $display("FAIL mid_sync: hs=%b vs=%b want 1 1", bus.h_sync, bus.v_sync);
        end
        reset = 1'b0;
        #1;
        tests_run++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 9'd0) begin
            fails++; $display("FAIL mid_refetch: en=%b we=%b addr=%0d want 1 0 0", bus.mem_en, bus.mem_we, bus.mem_addr);
        end
        @(negedge pixel_clk); #1;
        tests_run++; if (bus.frame_start !== 1'b1) begin fails++; $display("FAIL mid_fs: got %b want 1", bus.frame_start); end
    endtask

    initial begin
        reset = 1'b1;
        init_ram = 1'b1;
        bus.host_valid = 1'b0;
        bus.host_addr = '0;
        bus.host_data = '0;
        bus.err_clr = 1'b0;
        test_reset();
        test_frame();
        test_pixel();
        test_host_wait();
        test_back_to_back();
        test_error();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
